// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fir_ctrl_pkg
// Purpose : Shared types and constants for the time-multiplexed FIR MAC
//           scheduler: controller state encoding, default geometry and the
//           accumulator width helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package fir_ctrl_pkg;

   localparam int DEF_TAPS      = 4;
   localparam int DEF_DW        = 8;
   localparam int DEF_OUT_SHIFT = 8;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_IDLE = 2'd1,
      ST_MAC  = 2'd2,
      ST_DONE = 2'd3
   } fir_state_t;

   // Full-width product plus enough headroom that summing TAPS products
   // can never wrap.
   function automatic int acc_width(input int taps, input int dw);
      return 2 * dw + $clog2(taps);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac_unit.sv
`default_nettype none
// ============================================================================
// Module  : fir_mac_unit
// Purpose : Single shared multiplier plus accumulator. Clears on request,
//           accumulates coef*samp when enabled and, on the final tap,
//           captures the saturated, shifted running sum as the output.
// Ports   : clk, rst_n       clock, async active-low reset
//           acc_clr          zero the accumulator
//           acc_en           add coef*samp to the accumulator
//           out_en           last tap: latch saturated result into y_data
//           coef, samp       multiplier operands (DW bits, unsigned)
//           y_data           registered saturated result (DW bits)
// Rev     : 1.0  initial release
// ============================================================================
module fir_mac_unit
   import fir_ctrl_pkg::*;
#(
   parameter int DW        = DEF_DW,
   parameter int AW        = acc_width(DEF_TAPS, DEF_DW),
   parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          acc_clr,
   input  logic          acc_en,
   input  logic          out_en,
   input  logic [DW-1:0] coef,
   input  logic [DW-1:0] samp,
   output logic [DW-1:0] y_data
);

   logic [AW-1:0]   acc_q, acc_d;
   logic [DW-1:0]   y_q, y_d;
   logic [2*DW-1:0] prod;
   logic [AW-1:0]   acc_sum;
   logic [AW-1:0]   acc_shr;
   logic [DW-1:0]   y_sat;

   assign prod    = {{DW{1'b0}}, coef} * {{DW{1'b0}}, samp};
   assign acc_sum = acc_q + {{(AW-2*DW){1'b0}}, prod};
   assign acc_shr = acc_sum >> OUT_SHIFT;
   // Output uses the sum including the final tap's product, so the result
   // is available on the same edge that completes the last accumulate.
   assign y_sat   = (|acc_shr[AW-1:DW]) ? {DW{1'b1}} : acc_shr[DW-1:0];

   always_comb begin
      acc_d = acc_q;
      y_d   = y_q;
      if (acc_clr) begin
         acc_d = '0;
      end else if (acc_en) begin
         acc_d = acc_sum;
      end
      if (out_en) begin
         y_d = y_sat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         y_q   <= '0;
      end else begin
         acc_q <= acc_d;
         y_q   <= y_d;
      end
   end

   assign y_data = y_q;

endmodule
`default_nettype wire

// File: rtl/fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : fir_mac_scheduler
// Purpose : Controller for a small unsigned FIR filter that time-shares one
//           multiplier across all taps. Loads coefficients over a
//           valid/ready port, accepts one sample at a time, runs TAPS MAC
//           cycles and emits one saturated result per sample.
// Ports   : clk, rst_n                 clock, async active-low reset
//           coef_load                  reload request (honoured in IDLE)
//           coef_valid/ready/data      coefficient stream, h[0] first
//           sample_valid/ready/data    input sample handshake
//           y_valid, y_data            one-cycle result pulse / held result
//           busy                       high while a sample is in flight
// Rev     : 1.0  initial release
// ============================================================================
module fir_mac_scheduler
   import fir_ctrl_pkg::*;
#(
   parameter int TAPS      = DEF_TAPS,
   parameter int DW        = DEF_DW,
   parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          coef_load,
   input  logic          coef_valid,
   input  logic [DW-1:0] coef_data,
   output logic          coef_ready,
   input  logic          sample_valid,
   input  logic [DW-1:0] sample_data,
   output logic          sample_ready,
   output logic          y_valid,
   output logic [DW-1:0] y_data,
   output logic          busy
);

   localparam int CW = $clog2(TAPS);
   localparam int AW = acc_width(TAPS, DW);
   localparam logic [CW-1:0] CNT_LAST = CW'(TAPS - 1);

   fir_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] h_q [TAPS];
   logic [DW-1:0] h_d [TAPS];
   logic [DW-1:0] x_q [TAPS];
   logic [DW-1:0] x_d [TAPS];

   logic acc_clr;
   logic acc_en;
   logic out_en;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      h_d     = h_q;
      x_d     = x_q;
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      out_en  = 1'b0;
      case (state_q)
         ST_LOAD: begin
            // coef_ready is high throughout LOAD, so valid alone is a transfer.
            if (coef_valid) begin
               h_d[cnt_q] = coef_data;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_IDLE: begin
            // Reload wins over a concurrent sample; sample_ready is already
            // low in that case so the sample is simply not taken.
            if (coef_load) begin
               for (int i = 0; i < TAPS; i++) begin
                  x_d[i] = '0;
               end
               cnt_d   = '0;
               state_d = ST_LOAD;
            end else if (sample_valid) begin
               x_d[0] = sample_data;
               for (int i = 1; i < TAPS; i++) begin
                  x_d[i] = x_q[i-1];
               end
               acc_clr = 1'b1;
               cnt_d   = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_en = 1'b1;
            if (cnt_q == CNT_LAST) begin
               out_en  = 1'b1;
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         cnt_q   <= '0;
         for (int i = 0; i < TAPS; i++) begin
            h_q[i] <= '0;
            x_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < TAPS; i++) begin
            h_q[i] <= h_d[i];
            x_q[i] <= x_d[i];
         end
      end
   end

   fir_mac_unit #(
      .DW        (DW),
      .AW        (AW),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .acc_clr (acc_clr),
      .acc_en  (acc_en),
      .out_en  (out_en),
      .coef    (h_q[cnt_q]),
      .samp    (x_q[cnt_q]),
      .y_data  (y_data)
   );

   // Handshake outputs are pure state decodes, independent of *_valid.
   assign coef_ready   = (state_q == ST_LOAD);
   assign sample_ready = (state_q == ST_IDLE) && !coef_load;
   assign y_valid      = (state_q == ST_DONE);
   assign busy         = (state_q == ST_MAC) || (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_fir_mac_scheduler
// Purpose : Scoreboard bench for fir_mac_scheduler (TAPS=4, DW=8,
//           OUT_SHIFT=0). Driver pushes hand-computed results as samples
//           are accepted; a negedge monitor pops and compares on y_valid.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fir_mac_scheduler;

   localparam int TAPS = 4;
   localparam int DW   = 8;

   typedef logic [DW-1:0] coef_arr_t [TAPS];
   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          coef_load = 1'b0;
   logic          coef_valid = 1'b0;
   logic [DW-1:0] coef_data = '0;
   logic          coef_ready;
   logic          sample_valid = 1'b0;
   logic [DW-1:0] sample_data = '0;
   logic          sample_ready;
   logic          y_valid;
   logic [DW-1:0] y_data;
   logic          busy;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb[$];
   coef_arr_t hv;

   fir_mac_scheduler #(.TAPS(TAPS), .DW(DW), .OUT_SHIFT(0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .coef_load    (coef_load),
      .coef_valid   (coef_valid),
      .coef_data    (coef_data),
      .coef_ready   (coef_ready),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .sample_ready (sample_ready),
      .y_valid      (y_valid),
      .y_data       (y_data),
      .busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   // Monitor: every result pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && y_valid) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_y: got y_data=0x%0h, required no pulse", y_data);
         end else begin
            e = sb.pop_front();
            chk("y_data", int'(y_data), int'(e.data));
            chk("y_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic wait_sample_ready();
      int k = 0;
      while (!sample_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!sample_ready) chk("sample_ready_timeout", int'(sample_ready), 1);
   endtask

   task automatic wait_coef_ready();
      int k = 0;
      while (!coef_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("coef_ready_wait", int'(coef_ready), 1);
   endtask

   // Called at a negedge; returns at a negedge.
   task automatic send_sample(input logic [DW-1:0] d, input logic [DW-1:0] exp_y, input bit hold);
      int k = 0;
      exp_t e;
      wait_sample_ready();
      sample_valid = 1'b1;
      sample_data  = d;
      e.data = exp_y;
      e.cyc  = cyc + TAPS + 1;
      sb.push_back(e);
      @(negedge clk);
      if (hold) begin
         // Keep valid high through MAC and into DONE.
         while (!y_valid && k < 20) begin
            @(negedge clk);
            k++;
         end
      end
      sample_valid = 1'b0;
   endtask

   task automatic load_coefs(input coef_arr_t h, input bit gaps);
      wait_coef_ready();
      for (int i = 0; i < TAPS; i++) begin
         chk("coef_ready_in_load", int'(coef_ready), 1);
         coef_valid = 1'b1;
         coef_data  = h[i];
         @(negedge clk);
         if (gaps) begin
            coef_valid = 1'b0;
            coef_data  = 8'hEE;
            @(negedge clk);
         end
      end
      coef_valid = 1'b0;
      chk("coef_ready_after_load", int'(coef_ready), 0);
      chk("sample_ready_after_load", int'(sample_ready), 1);
   endtask

   task automatic request_load();
      wait_sample_ready();
      coef_load = 1'b1;
      @(negedge clk);
      wait_coef_ready();
      coef_load = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_coef_ready", int'(coef_ready), 1);
      chk("rst_sample_ready", int'(sample_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_y_valid", int'(y_valid), 0);
      chk("rst_y_data", int'(y_data), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic filtering, h = 1,2,3,4
      hv = '{8'd1, 8'd2, 8'd3, 8'd4};
      load_coefs(hv, 1'b0);
      send_sample(8'h10, 8'h10, 1'b0);
      chk("busy_in_mac", int'(busy), 1);
      chk("sample_ready_in_mac", int'(sample_ready), 0);
      send_sample(8'h20, 8'h40, 1'b0);
      send_sample(8'h30, 8'hA0, 1'b0);

      // coef_load and sample_valid together in IDLE
      wait_sample_ready();
      coef_load    = 1'b1;
      sample_valid = 1'b1;
      sample_data  = 8'h55;
      @(negedge clk);
      chk("load_wins_coef_ready", int'(coef_ready), 1);
      chk("load_wins_sample_ready", int'(sample_ready), 0);
      chk("y_data_held", int'(y_data), 8'hA0);
      coef_load    = 1'b0;
      sample_valid = 1'b0;
      // Gapped coefficient stream; gap data is junk and must be ignored.
      hv = '{8'd0, 8'd0, 8'd0, 8'd1};
      load_coefs(hv, 1'b1);
      send_sample(8'h80, 8'h00, 1'b0);
      send_sample(8'h00, 8'h00, 1'b0);
      send_sample(8'h00, 8'h00, 1'b0);
      send_sample(8'h00, 8'h80, 1'b0);

      // sample_valid held through MAC/DONE must shift only once
      send_sample(8'h05, 8'h00, 1'b1);
      send_sample(8'h07, 8'h00, 1'b0);
      send_sample(8'h09, 8'h00, 1'b0);
      send_sample(8'h0B, 8'h05, 1'b0);

      // Saturation with full-scale coefficients and samples
      request_load();
      hv = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      load_coefs(hv, 1'b0);
      for (int i = 0; i < 4; i++) send_sample(8'hFF, 8'hFF, 1'b0);

      // Saturation boundary: 0xFF passes, 0x100 clips
      request_load();
      hv = '{8'd1, 8'd1, 8'd0, 8'd0};
      load_coefs(hv, 1'b0);
      send_sample(8'hFE, 8'hFE, 1'b0);
      send_sample(8'h01, 8'hFF, 1'b0);
      send_sample(8'hFF, 8'hFF, 1'b0);

      // coef_load pulsed during MAC is ignored
      send_sample(8'h00, 8'hFF, 1'b0);
      coef_load = 1'b1;
      @(negedge clk);
      coef_load = 1'b0;
      chk("no_load_from_mac", int'(coef_ready), 0);
      for (int k = 0; k < 20 && !y_valid; k++) @(negedge clk);
      @(negedge clk);
      chk("idle_after_done_coef_ready", int'(coef_ready), 0);
      chk("idle_after_done_sample_ready", int'(sample_ready), 1);
      send_sample(8'h02, 8'h02, 1'b0);

      // Reset in the second MAC cycle aborts the sample
      wait_sample_ready();
      sample_valid = 1'b1;
      sample_data  = 8'h11;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_coef_ready", int'(coef_ready), 1);
      chk("mid_rst_y_data", int'(y_data), 0);
      chk("mid_rst_y_valid", int'(y_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("post_rst_stays_load", int'(coef_ready), 1);
      hv = '{8'd1, 8'd1, 8'd1, 8'd1};
      load_coefs(hv, 1'b0);
      send_sample(8'h01, 8'h01, 1'b0);
      send_sample(8'h02, 8'h03, 1'b0);

      // Drain outstanding results
      for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fir_mac_scheduler.md
# fir_mac_scheduler

Time-multiplexed controller for the team's small unsigned FIR filter. It loads the tap coefficients over a valid/ready port after reset, or on request. It accepts one input sample at a time and sequences a single shared 8×8 multiplier across all taps. It then emits one saturated 8-bit result per sample. It sits between the pin-level wrapper (ui_in/uio_in/uo_out) and replaces the fully parallel per-tap multiply with one MAC.

## Interface
- TAPS, 4: number of filter taps, 2..8
- DW, 8: sample and coefficient width, unsigned
- OUT_SHIFT, 8: right shift applied to the accumulator before output
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- coef_load  in  1  request to reload coefficients; sampled only in IDLE
- coef_valid  in  1  coefficient word valid
- coef_data  in  DW  coefficient word; h[0] first
- coef_ready  out  1  high in LOAD
- sample_valid  in  1  input sample valid
- sample_data  in  DW  input sample
- sample_ready  out  1  high in IDLE when coef_load=0
- y_valid  out  1  one-cycle pulse, result valid
- y_data  out  DW  filtered result; holds its value between pulses
- busy  out  1  high in MAC or DONE

## Operation
- **States:** LOAD, IDLE, MAC, DONE. Reset state is LOAD.
- **LOAD**
  - A transfer occurs on each edge with coef_valid&coef_ready.
  - The word is written to h[cnt] and cnt increments.
  - After the TAPS-th transfer: cnt←0, go to IDLE.
  - Words arriving with no coef_valid are not counted.
- **IDLE**
  - If coef_load=1: go to LOAD, clear the delay line x[0..TAPS-1] to 0, cnt←0. Any concurrent sample is not accepted, because sample_ready=0.
  - Else if sample_valid: shift the delay line (x[0]←sample_data, x[i]←x[i-1]), acc←0, cnt←0, go to MAC.
- **MAC:** each cycle acc ← acc + h[cnt]*x[cnt], cnt+1. After cnt=TAPS-1, go to DONE.
- **DONE**
  - y_data ← min(acc>>OUT_SHIFT, 2^DW−1) and y_valid=1 for this one cycle.
  - Go to IDLE.
- **Arithmetic:** unsigned. Product is 2·DW bits. acc width is 2·DW+clog2(TAPS), so there is no wrap. Saturation applies only at the output.
- coef_load asserted outside IDLE is ignored. The requester must hold it until coef_ready rises.
- Coefficients persist across samples until the next LOAD. Reset clears h[] and x[] to 0.
- **Reset values:** y_data=0, y_valid=0, busy=0. coef_ready=1 (LOAD), sample_ready=0. Transfers happen only on edges with rst_n high.
- **Reset mid-operation** (any state): async return to LOAD with all registers cleared. No y_valid pulse is produced for the aborted sample.

## Timing
- Sample accepted on edge T. MAC occupies T+1..T+TAPS. y_valid is high in cycle T+TAPS+1, and y_data updates on that same edge.
- **Throughput:** one sample per TAPS+2 cycles; sample_ready is low in MAC and DONE.
- **Coefficient load:** minimum TAPS cycles when coef_valid is held high. sample_ready rises the cycle after the last transfer.
- coef_ready and sample_ready are decoded from the state register (sample_ready also gated by coef_load). They have no dependence on the *_valid inputs.

## Structure
- Package fir_ctrl_pkg:
  - state enum {LOAD, IDLE, MAC, DONE}
  - default TAPS/DW/OUT_SHIFT constants
  - accumulator-width function
- Sub-module fir_mac_unit: holds acc and performs clear, accumulate and saturate-out. It contains the single shared multiplier.
- The top block owns the FSM, the counter, h[] and the delay line.

## Test plan
- **Reset load:** reset, then load h=1,2,3,4. Feed samples 0x10, 0x20, 0x30 one at a time. Required outputs (OUT_SHIFT=0 variant, DW=8): 0x10, 0x40, 0xA0, one pulse each, each TAPS+1 cycles after acceptance.
- **Saturation:** h=0xFF×4, samples 0xFF×4 with OUT_SHIFT=8. acc reaches 4·0xFE01; y_data=0xFF on the 4th result.
- **Handshake gaps:** coef_valid toggled 1,0,1,0… Exactly 4 transfers are taken and the gap cycles are not counted. sample_valid held high during MAC/DONE does not shift x.
- **Simultaneous coef_load and sample_valid in IDLE:** LOAD entered, sample not taken, delay line zeroed. After reload h=0,0,0,1, an impulse 0x80 gives 0x00, 0x00, 0x00, 0x80 across four samples (OUT_SHIFT=0).
- **Reset during MAC (cycle T+2):** no y_valid. State is LOAD, coef_ready=1, y_data=0, h[] zero.
- **coef_load pulsed during MAC:** ignored. The result is still produced, and the block returns to IDLE without entering LOAD.
